// File: rtl/regfile_write_buffer_pkg.sv
// regfile_write_buffer_pkg: shared constants and pointer-width helper for the write buffer
package regfile_write_buffer_pkg;
  localparam int default_depth = 4;
  function automatic int ptr_w(input int d);
    return $clog2(d);
  endfunction
endpackage

// File: rtl/regfile_write_buffer_match.sv
// regfile_write_buffer_match: youngest-match search over the buffered (index, data) entries
module regfile_write_buffer_match
  import regfile_write_buffer_pkg::*;
#(
  parameter int width = 1,
  parameter int n     = 1,
  parameter int depth = default_depth
) (
  input  logic [depth-1:0]       valid,
  input  logic [depth*n-1:0]     idx,
  input  logic [depth*width-1:0] data,
  input  logic [ptr_w(depth)-1:0] head,
  input  logic [n-1:0]           probe,
  output logic                   hit,
  output logic [width-1:0]       hit_data
);
  localparam int pw = ptr_w(depth);
  logic [pw-1:0] s;
  // walk entries oldest to youngest from the head so the last match wins
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    s = '0;
    for (int k = 0; k < depth; k++) begin
      s = head + pw'(k);
      if (valid[s] && idx[int'(s)*n +: n] == probe) begin
        hit = 1'b1;
        hit_data = data[int'(s)*width +: width];
      end
    end
  end
endmodule

// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer: FIFO of pending register-file writes with read forwarding
module regfile_write_buffer
  import regfile_write_buffer_pkg::*;
#(
  parameter int width = 1,
  parameter int n     = 1,
  parameter int depth = default_depth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [n-1:0]          enq_index,
  input  logic [width-1:0]      enq_data,
  input  logic                  drain_en,
  output logic                  wr_en,
  output logic [n-1:0]          wr_index,
  output logic [width-1:0]      wr_data,
  input  logic [n-1:0]          lookup_index,
  output logic                  lookup_hit,
  output logic [width-1:0]      lookup_data,
  output logic [ptr_w(depth):0] count
);
  localparam int pw = ptr_w(depth);
  localparam int cw = pw + 1;
  localparam logic [cw-1:0] full = cw'(depth);
  logic [cw-1:0] count_q, count_d;
  logic [pw-1:0] head_q, head_d, tail_q, tail_d;
  logic [depth-1:0] vld_q, vld_d;
  logic [depth*n-1:0] idx_q, idx_d;
  logic [depth*width-1:0] data_q, data_d;
  logic push, pop;
  assign enq_ready = count_q < full;
  assign wr_en = (count_q != '0) && drain_en;
  assign push = enq_valid && enq_ready;
  assign pop = wr_en;
  assign wr_index = idx_q[int'(head_q)*n +: n];
  assign wr_data = data_q[int'(head_q)*width +: width];
  assign count = count_q;
  // next-state: pop at head, append at tail, occupancy tracks the difference
  always_comb begin
    count_d = count_q + cw'(push) - cw'(pop);
    head_d = pop ? head_q + pw'(1) : head_q;
    tail_d = push ? tail_q + pw'(1) : tail_q;
    vld_d = vld_q;
    idx_d = idx_q;
    data_d = data_q;
    if (pop) vld_d[head_q] = 1'b0;
    if (push) begin
      vld_d[tail_q] = 1'b1;
      idx_d[int'(tail_q)*n +: n] = enq_index;
      data_d[int'(tail_q)*width +: width] = enq_data;
    end
  end
  // control state is reset; reset drops every pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      vld_q <= '0;
    end else begin
      count_q <= count_d;
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q <= vld_d;
    end
  end
  // entry payload needs no reset since the valid bits gate every use
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    data_q <= data_d;
  end
  regfile_write_buffer_match #(.width(width), .n(n), .depth(depth)) u_match (
    .valid    (vld_q),
    .idx      (idx_q),
    .data     (data_q),
    .head     (head_q),
    .probe    (lookup_index),
    .hit      (lookup_hit),
    .hit_data (lookup_data)
  );
endmodule

// File: tb/tb_regfile_write_buffer.sv
// tb_regfile_write_buffer: randomized and directed checks against a queue model
module tb_regfile_write_buffer;
  localparam int width = 8;
  localparam int n = 4;
  localparam int depth = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic enq_valid = 1'b0, enq_ready, drain_en = 1'b0, wr_en, lookup_hit;
  logic [n-1:0] enq_index = '0, wr_index, lookup_index = '0;
  logic [width-1:0] enq_data = '0, wr_data, lookup_data;
  logic [2:0] count;
  int checks = 0, failures = 0;
  logic [n+width-1:0] q[$];
  always #5 clk = ~clk;
  regfile_write_buffer #(.width(width), .n(n), .depth(depth)) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_index(enq_index), .enq_data(enq_data), .drain_en(drain_en),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
    .lookup_index(lookup_index), .lookup_hit(lookup_hit),
    .lookup_data(lookup_data), .count(count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // apply inputs, compare outputs against the model, then advance one clock
  task automatic step(input logic r, input logic ev, input int idx, input int dat,
                      input logic dr, input int look);
    logic ehit;
    logic [width-1:0] edat;
    logic acc, popx;
    rst = r; enq_valid = ev; enq_index = n'(idx); enq_data = width'(dat);
    drain_en = dr; lookup_index = n'(look);
    #1;
    ehit = 1'b0; edat = '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (!ehit && q[i][n+width-1:width] == n'(look)) begin
        ehit = 1'b1; edat = q[i][width-1:0];
      end
    chk("count", 32'(count), 32'(q.size()));
    chk("enq_ready", 32'(enq_ready), 32'(q.size() < depth));
    chk("wr_en", 32'(wr_en), 32'(q.size() > 0 && dr));
    if (q.size() > 0 && dr) begin
      chk("wr_index", 32'(wr_index), 32'(q[0][n+width-1:width]));
      chk("wr_data", 32'(wr_data), 32'(q[0][width-1:0]));
    end
    chk("lookup_hit", 32'(lookup_hit), 32'(ehit));
    chk("lookup_data", 32'(lookup_data), 32'(edat));
    acc = ev && q.size() < depth;
    popx = dr && q.size() > 0;
    @(posedge clk);
    if (r) q.delete();
    else begin
      if (popx) void'(q.pop_front());
      if (acc) q.push_back({n'(idx), width'(dat)});
    end
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    step(1, 1, 9, 9, 1, 0);
    step(0, 1, 3, 'hA, 1, 3);
    #1;
    chk("d25_wr_en", 32'(wr_en), 1);
    chk("d25_wr_index", 32'(wr_index), 3);
    chk("d25_wr_data", 32'(wr_data), 'hA);
    step(0, 0, 0, 0, 1, 3);
    #1;
    chk("d25_count0", 32'(count), 0);
    chk("d25_wr_en0", 32'(wr_en), 0);
    for (int i = 0; i < 4; i++) step(0, 1, i + 1, 'h10 + i, 0, 0);
    #1;
    chk("d26_ready0", 32'(enq_ready), 0);
    chk("d26_count4", 32'(count), 4);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 0);
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 1, 0, 5);
    step(0, 1, 5, 2, 0, 5);
    step(0, 0, 0, 0, 0, 5);
    #1;
    chk("d27_hit5", 32'(lookup_hit), 1);
    chk("d27_data5", 32'(lookup_data), 2);
    lookup_index = 6;
    #1;
    chk("d27_hit6", 32'(lookup_hit), 0);
    chk("d27_data6", 32'(lookup_data), 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 7 + i, 'h20 + i, 0, 7);
    for (int i = 0; i < 14; i++) begin
      step(0, 1, i % 16, 'h30 + i, 1, i % 16);
      #1;
      chk("d28_count_band", 32'(count >= 3'(depth - 1)), 1);
    end
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 2, 'h40 + i, 0, 2);
    step(1, 1, 2, 'h77, 1, 2);
    #1;
    chk("d29_count0", 32'(count), 0);
    chk("d29_hit0", 32'(lookup_hit), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 2);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 3),
           $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 3));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
